// File: rtl/iiitb_rv32i_mem_arb.sv
// iiitb_rv32i_mem_arb
// Two-requester arbiter and boot sequencer for the single-port memory behind
// the iiitb_rv32i core. In BOOT only the program loader reaches memory and
// the core is held stalled. After ld_done the core runs and has fixed
// priority over the loader. Read data returns one cycle after the grant, to
// whichever requester owned that read.
// Optional feature: define RV32I_ARB_STARVE_EN to force a loader grant after
// MAX_WAIT consecutive denied cycles in RUN.
module iiitb_rv32i_mem_arb #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    input  logic              ld_done,
    output logic              core_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic {BOOT, RUN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_LD} own_t;

    state_t state_q;
    logic   core_hold_q;
    own_t   rd_own_q, rd_own_d;
    logic   force_ld;

`ifdef RV32I_ARB_STARVE_EN
    localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] wait_q, wait_d;

    assign force_ld = (state_q == RUN) && (wait_q == CNT_W'(MAX_WAIT));

    // Count consecutive denied loader cycles in RUN, saturating at MAX_WAIT
    always_comb begin
        wait_d = '0;
        if ((state_q == RUN) && ld_req && !ld_gnt) begin
            wait_d = (wait_q == CNT_W'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
        end
    end

    // Starvation counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    // Without the starvation guard the loader is never forced; this
    // expression is constant false and only ties off the unused parameter
    assign force_ld = (MAX_WAIT < 0);
`endif

    // Combinational grant: loader only in BOOT, core priority in RUN,
    // everything suppressed while reset is asserted
    always_comb begin
        core_gnt = 1'b0;
        ld_gnt   = 1'b0;
        if (!rst) begin
            if (state_q == BOOT) begin
                ld_gnt = ld_req;
            end else if (force_ld && ld_req) begin
                ld_gnt = 1'b1;
            end else begin
                core_gnt = core_req;
                ld_gnt   = ld_req & ~core_req;
            end
        end
    end

    // Route the granted requester onto the memory port, zero when idle
    always_comb begin
        mem_en    = core_gnt | ld_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_own_d  = OWN_NONE;
        if (core_gnt) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            rd_own_d  = core_we ? OWN_NONE : OWN_CORE;
        end else if (ld_gnt) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            rd_own_d  = ld_we ? OWN_NONE : OWN_LD;
        end
    end

    // Boot/run sequencer with registered core stall; leaves BOOT on ld_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            core_hold_q <= 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    if (ld_done) begin
                        state_q     <= RUN;
                        core_hold_q <= 1'b0;
                    end
                end
                RUN: begin
                    state_q     <= RUN;
                    core_hold_q <= 1'b0;
                end
                default: begin
                    state_q     <= BOOT;
                    core_hold_q <= 1'b1;
                end
            endcase
        end
    end

    // Remember who issued the read so the returning data is steered there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_own_q <= OWN_NONE;
        end else begin
            rd_own_q <= rd_own_d;
        end
    end

    assign core_hold   = core_hold_q;
    assign core_rvalid = (rd_own_q == OWN_CORE);
    assign ld_rvalid   = (rd_own_q == OWN_LD);
    assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
    assign ld_rdata    = ld_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_iiitb_rv32i_mem_arb.sv
// Testbench for iiitb_rv32i_mem_arb: drives core and loader traffic through
// boot and run phases against a small synchronous memory, and checks read
// returns against a scoreboard of expected owner/data/cycle entries.
module tb_iiitb_rv32i_mem_arb;

    localparam int ADDR_W   = 10;
    localparam int MAX_WAIT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              coreReq, coreWe, ldReq, ldWe, ldDone;
    logic [ADDR_W-1:0] coreAddr, ldAddr;
    logic [31:0]       coreWdata, ldWdata;
    logic              coreGnt, coreRvalid, ldGnt, ldRvalid, coreHold;
    logic [31:0]       coreRdata, ldRdata;
    logic              memEn, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [31:0]       memRdata = 32'h0;

    logic [31:0] memArray [0:(1<<ADDR_W)-1];

    typedef struct {
        logic        isCore;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   cycleCnt    = 0;
    int   testsRun    = 0;
    int   testsFailed = 0;

    iiitb_rv32i_mem_arb #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .core_req(coreReq), .core_we(coreWe), .core_addr(coreAddr),
        .core_wdata(coreWdata), .core_gnt(coreGnt), .core_rvalid(coreRvalid),
        .core_rdata(coreRdata),
        .ld_req(ldReq), .ld_we(ldWe), .ld_addr(ldAddr), .ld_wdata(ldWdata),
        .ld_gnt(ldGnt), .ld_rvalid(ldRvalid), .ld_rdata(ldRdata),
        .ld_done(ldDone), .core_hold(coreHold),
        .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr),
        .mem_wdata(memWdata), .mem_rdata(memRdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory seen by the arbiter
    always @(posedge clk) begin
        cycleCnt++;
        if (memEn) begin
            if (memWe) memArray[memAddr] <= memWdata;
            else       memRdata <= memArray[memAddr];
        end
    end

    // Scoreboard: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
            testsRun++; testsFailed++;
            $display("[TB] FAIL missing_rvalid: no rvalid seen, required one at cycle %0d", expQ[0].cyc);
            void'(expQ.pop_front());
        end
        if (coreRvalid || ldRvalid) begin
            testsRun++;
            if (coreRvalid && ldRvalid) begin
                testsFailed++;
                $display("[TB] FAIL rvalid_both: core_rvalid=1 ld_rvalid=1, required only one");
            end else if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL rvalid_unexpected: core_rvalid=%0b ld_rvalid=%0b at cycle %0d, required none", coreRvalid, ldRvalid, cycleCnt);
            end else begin
                e = expQ.pop_front();
                if (e.cyc !== cycleCnt || coreRvalid !== e.isCore
                    || (e.isCore ? coreRdata : ldRdata) !== e.data
                    || (e.isCore ? ldRdata : coreRdata) !== 32'h0) begin
                    testsFailed++;
                    $display("[TB] FAIL rvalid_data: got core=%0b cyc=%0d crdata=%h lrdata=%h, required core=%0b cyc=%0d data=%h",
                             coreRvalid, cycleCnt, coreRdata, ldRdata, e.isCore, e.cyc, e.data);
                end
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        coreReq = 0; coreWe = 0; coreAddr = '0; coreWdata = '0;
        ldReq = 0; ldWe = 0; ldAddr = '0; ldWdata = '0; ldDone = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        coreReq = 1; ldReq = 1; ldWe = 1; ldWdata = 32'hFFFF_FFFF;
        repeat (2) nextCycle();
        #1;
        testsRun++;
        if (coreHold !== 1'b1 || coreGnt !== 1'b0 || ldGnt !== 1'b0 || memEn !== 1'b0
            || memWdata !== 32'h0 || coreRvalid !== 1'b0 || ldRvalid !== 1'b0
            || coreRdata !== 32'h0 || ldRdata !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: hold=%0b cg=%0b lg=%0b en=%0b wd=%h crv=%0b lrv=%0b, required 1 0 0 0 0 0 0",
                     coreHold, coreGnt, ldGnt, memEn, memWdata, coreRvalid, ldRvalid);
        end
        idleInputs();
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_boot();
        // Loader writes word 0 while the core tries to read address 5
        nextCycle();
        ldReq = 1; ldWe = 1; ldAddr = 0; ldWdata = 32'h00222000;
        coreReq = 1; coreWe = 0; coreAddr = 5;
        #1;
        testsRun++;
        if (ldGnt !== 1 || coreGnt !== 0 || memEn !== 1 || memWe !== 1 || memAddr !== 0
            || memWdata !== 32'h00222000 || coreHold !== 1) begin
            testsFailed++;
            $display("[TB] FAIL boot_write0: lg=%0b cg=%0b en=%0b we=%0b a=%0d wd=%h hold=%0b, required 1 0 1 1 0 00222000 1",
                     ldGnt, coreGnt, memEn, memWe, memAddr, memWdata, coreHold);
        end
        nextCycle();
        ldAddr = 1; ldWdata = 32'h04432800;
        #1;
        testsRun++;
        if (ldGnt !== 1 || coreGnt !== 0 || memAddr !== 1 || memWdata !== 32'h04432800 || coreHold !== 1) begin
            testsFailed++;
            $display("[TB] FAIL boot_write1: lg=%0b cg=%0b a=%0d wd=%h hold=%0b, required 1 0 1 04432800 1",
                     ldGnt, coreGnt, memAddr, memWdata, coreHold);
        end
        nextCycle();
        ldWe = 0; ldWdata = '0;
        #1;
        testsRun++;
        if (ldGnt !== 1 || coreGnt !== 0 || memEn !== 1 || memWe !== 0 || memAddr !== 1 || coreHold !== 1) begin
            testsFailed++;
            $display("[TB] FAIL boot_read1: lg=%0b cg=%0b en=%0b we=%0b a=%0d hold=%0b, required 1 0 1 0 1 1",
                     ldGnt, coreGnt, memEn, memWe, memAddr, coreHold);
        end
        expQ.push_back('{isCore: 1'b0, data: 32'h04432800, cyc: cycleCnt + 1});
        nextCycle();
        ldReq = 0; ldDone = 1;
        #1;
        testsRun++;
        if (coreGnt !== 0 || memEn !== 0 || coreHold !== 1) begin
            testsFailed++;
            $display("[TB] FAIL boot_core_ignored: cg=%0b en=%0b hold=%0b, required 0 0 1", coreGnt, memEn, coreHold);
        end
        // ld_done was sampled: core released and granted in the same cycle
        nextCycle();
        ldDone = 0;
        #1;
        testsRun++;
        if (coreHold !== 0 || coreGnt !== 1 || memAddr !== 5) begin
            testsFailed++;
            $display("[TB] FAIL boot_release: hold=%0b cg=%0b a=%0d, required 0 1 5", coreHold, coreGnt, memAddr);
        end
        expQ.push_back('{isCore: 1'b1, data: 32'h0, cyc: cycleCnt + 1});
        nextCycle();
        idleInputs();
        nextCycle();
    endtask

    task automatic test_priority();
        coreReq = 1; coreWe = 0; coreAddr = 0;
        ldReq = 1; ldWe = 1; ldAddr = 47; ldWdata = 32'h01AE6000;
        #1;
        testsRun++;
        if (coreGnt !== 1 || ldGnt !== 0 || memWe !== 0 || memAddr !== 0) begin
            testsFailed++;
            $display("[TB] FAIL prio_core_wins: cg=%0b lg=%0b we=%0b a=%0d, required 1 0 0 0", coreGnt, ldGnt, memWe, memAddr);
        end
        expQ.push_back('{isCore: 1'b1, data: 32'h00222000, cyc: cycleCnt + 1});
        nextCycle();
        coreReq = 0;
        #1;
        testsRun++;
        if (ldGnt !== 1 || coreGnt !== 0 || memWe !== 1 || memAddr !== 47 || memWdata !== 32'h01AE6000) begin
            testsFailed++;
            $display("[TB] FAIL prio_ld_next: lg=%0b cg=%0b we=%0b a=%0d wd=%h, required 1 0 1 47 01ae6000",
                     ldGnt, coreGnt, memWe, memAddr, memWdata);
        end
        nextCycle();
        idleInputs();
        nextCycle();
    endtask

    task automatic test_back_to_back();
        coreReq = 1; coreWe = 0; coreAddr = 0;
        #1;
        testsRun++;
        if (coreGnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_core0: cg=%0b, required 1", coreGnt);
        end
        expQ.push_back('{isCore: 1'b1, data: 32'h00222000, cyc: cycleCnt + 1});
        nextCycle();
        coreReq = 0; ldReq = 1; ldWe = 0; ldAddr = 47;
        #1;
        testsRun++;
        if (ldGnt !== 1 || memAddr !== 47) begin
            testsFailed++;
            $display("[TB] FAIL b2b_ld47: lg=%0b a=%0d, required 1 47", ldGnt, memAddr);
        end
        expQ.push_back('{isCore: 1'b0, data: 32'h01AE6000, cyc: cycleCnt + 1});
        nextCycle();
        ldReq = 0; coreReq = 1; coreAddr = 1;
        #1;
        testsRun++;
        if (coreGnt !== 1 || memAddr !== 1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_core1: cg=%0b a=%0d, required 1 1", coreGnt, memAddr);
        end
        expQ.push_back('{isCore: 1'b1, data: 32'h04432800, cyc: cycleCnt + 1});
        nextCycle();
        idleInputs();
        repeat (2) nextCycle();
    endtask

    task automatic test_ld_done_ignored();
        ldDone = 1;
        nextCycle();
        ldDone = 0;
        repeat (2) nextCycle();
        testsRun++;
        if (coreHold !== 0) begin
            testsFailed++;
            $display("[TB] FAIL run_ld_done_ignored: hold=%0b, required 0", coreHold);
        end
    endtask

    task automatic test_reset_mid_read();
        coreReq = 1; coreWe = 0; coreAddr = 1;
        #1;
        testsRun++;
        if (coreGnt !== 1) begin
            testsFailed++;
            $display("[TB] FAIL midrd_grant: cg=%0b, required 1", coreGnt);
        end
        nextCycle();
        rst = 1;
        #1;
        testsRun++;
        if (coreHold !== 1 || coreRvalid !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midrd_reset: hold=%0b crv=%0b, required 1 0", coreHold, coreRvalid);
        end
        nextCycle();
        rst = 0;
        // Back in BOOT: the held core request must still be refused
        nextCycle();
        #1;
        testsRun++;
        if (coreGnt !== 0 || coreHold !== 1 || memEn !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midrd_boot: cg=%0b hold=%0b en=%0b, required 0 1 0", coreGnt, coreHold, memEn);
        end
        idleInputs();
        repeat (2) nextCycle();
    endtask

    task automatic test_starvation();
        int ldGrants = 0;
        ldDone = 1;
        nextCycle();
        ldDone = 0;
        coreReq = 1; coreWe = 1; coreAddr = 100; coreWdata = 32'hC0C0C0C0;
        ldReq = 1; ldWe = 1; ldAddr = 200; ldWdata = 32'h1D1D1D1D;
`ifdef RV32I_ARB_STARVE_EN
        for (int i = 1; i <= MAX_WAIT + 2; i++) begin
            #1;
            testsRun++;
            if (ldGnt !== (i == MAX_WAIT + 1) || coreGnt !== (i != MAX_WAIT + 1)) begin
                testsFailed++;
                $display("[TB] FAIL starve_cycle%0d: lg=%0b cg=%0b, required lg=%0b cg=%0b",
                         i, ldGnt, coreGnt, (i == MAX_WAIT + 1), (i != MAX_WAIT + 1));
            end
            nextCycle();
        end
`else
        for (int i = 0; i < 50; i++) begin
            #1;
            if (ldGnt) ldGrants++;
            nextCycle();
        end
        testsRun++;
        if (ldGrants !== 0) begin
            testsFailed++;
            $display("[TB] FAIL starve_none: loader granted %0d times in 50 cycles, required 0", ldGrants);
        end
`endif
        idleInputs();
        nextCycle();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) memArray[i] = 32'h0;
        test_reset();
        test_boot();
        test_priority();
        test_back_to_back();
        test_ld_done_ignored();
        test_reset_mid_read();
        test_starvation();
        repeat (3) nextCycle();
        testsRun++;
        if (expQ.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: %0d reads outstanding, required 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
